vec_normalize: RTL and testbench

Downstream stage of the vector-magnitude unit in the ray tracer datapath. Takes a direction vector (x, y, z) together with its 11-bit integer magnitude and produces the unit vector in signed fixed point, one component at a time, using a shared iterative restoring divider. It uses a valid/ready handshake on both sides, so it can absorb the magnitude unit's fixed latency and stall on a busy consumer.

---
 rtl/vec_pkg.sv | 25 ++
 rtl/norm_div.sv | 78 +++++++
 rtl/vec_normalize.sv | 168 ++++++++++++++++
 tb/tb_vec_normalize.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector-normalize stage of the ray tracer datapath.
package vec_pkg;
  localparam int COMP_W   = 20;
  localparam int MAG_W    = 11;
  localparam int FRAC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV_X = 3'd1,
    DIV_Y = 3'd2,
    DIV_Z = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic signed [FRAC_DEF+1:0] fix_t;

  // Magnitude of a two's-complement component; -2^19 maps to 2^19, which still fits unsigned.
  function automatic logic [COMP_W-1:0] abs_c(input logic [COMP_W-1:0] c);
    if (c[COMP_W-1]) begin
      return ~c + {{(COMP_W-1){1'b0}}, 1'b1};
    end else begin
      return c;
    end
  endfunction
endpackage

// File: rtl/norm_div.sv
// Restoring divider for one component: FRAC+1 quotient bits, one per cycle,
// the first bit computed on the start edge itself.
module norm_div
  import vec_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAG_W-1:0] num,
  input  logic [MAG_W-1:0] mag,
  output logic             busy,
  output logic             done,
  output logic [FRAC:0]    q
);
  localparam int REM_W = MAG_W + 1;
  localparam int CNT_W = $clog2(FRAC + 2);

  logic [REM_W-1:0] rem_r;
  logic [FRAC:0]    q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [REM_W-1:0] trial_s;
  logic [REM_W-1:0] next_rem_s;
  logic             ge_s;

  // One restoring step: load the dividend on start, otherwise double the remainder.
  always_comb begin
    trial_s    = {REM_W{1'b0}};
    next_rem_s = {REM_W{1'b0}};
    if (start) begin
      trial_s = {1'b0, num};
    end else begin
      trial_s = {rem_r[REM_W-2:0], 1'b0};
    end
    ge_s = (trial_s >= {1'b0, mag});
    if (ge_s) begin
      next_rem_s = trial_s - {1'b0, mag};
    end else begin
      next_rem_s = trial_s;
    end
  end

  // Step sequencing; done pulses for one cycle after the last quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= {REM_W{1'b0}};
      q_r    <= {(FRAC+1){1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= next_rem_s;
      q_r    <= {{FRAC{1'b0}}, ge_s};
      cnt_r  <= CNT_W'(1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      rem_r <= next_rem_s;
      q_r   <= {q_r[FRAC-1:0], ge_s};
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == CNT_W'(FRAC)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
endmodule

// File: rtl/vec_normalize.sv
// Unit-vector stage: divides x, y, z by the integer magnitude in turn on one shared divider
// and presents the signed fixed-point result behind a valid/ready handshake.
module vec_normalize
  import vec_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COMP_W-1:0] x,
  input  logic [COMP_W-1:0] y,
  input  logic [COMP_W-1:0] z,
  input  logic [MAG_W-1:0]  mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC+1:0]   nx,
  output logic [FRAC+1:0]   ny,
  output logic [FRAC+1:0]   nz,
  output logic              zero_vec
);
  state_t            state_r;
  logic [COMP_W-1:0] y_r, z_r;
  logic [MAG_W-1:0]  mag_r;
  logic              neg_r, sat_r;
  logic              in_ready_r, out_valid_r, zero_vec_r;
  logic [FRAC+1:0]   nx_r, ny_r, nz_r;

  logic [COMP_W-1:0] start_c_s, start_abs_s;
  logic [MAG_W-1:0]  start_mag_s;
  logic              start_s, start_sat_s, div_start_s;
  logic              div_busy_s, div_done_s;
  logic [FRAC:0]     div_q_s;
  logic [FRAC+1:0]   mag_q_s, res_s;

  // Pick the component whose division begins this cycle; x comes straight from the port.
  always_comb begin
    start_c_s   = {COMP_W{1'b0}};
    start_mag_s = mag_r;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        start_c_s   = x;
        start_mag_s = mag;
        start_s     = in_valid;
      end
      DIV_X: begin
        start_c_s = y_r;
        start_s   = div_done_s;
      end
      DIV_Y: begin
        start_c_s = z_r;
        start_s   = div_done_s;
      end
      default: begin
        start_c_s   = {COMP_W{1'b0}};
        start_mag_s = mag_r;
        start_s     = 1'b0;
      end
    endcase
    start_abs_s = abs_c(start_c_s);
    start_sat_s = (start_abs_s > {{(COMP_W-MAG_W){1'b0}}, start_mag_s});
    div_start_s = start_s & ~div_busy_s;
  end

  norm_div #(.FRAC(FRAC)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start_s),
    .num   (start_abs_s[MAG_W-1:0]),
    .mag   (start_mag_s),
    .busy  (div_busy_s),
    .done  (div_done_s),
    .q     (div_q_s)
  );

  // A wrapped upstream sum gives |c| > mag; clamp to exactly 1.0 instead of trusting the quotient.
  always_comb begin
    mag_q_s = {(FRAC+2){1'b0}};
    res_s   = {(FRAC+2){1'b0}};
    if (mag_r == {MAG_W{1'b0}}) begin
      mag_q_s = {(FRAC+2){1'b0}};
    end else if (sat_r) begin
      mag_q_s = {2'b01, {FRAC{1'b0}}};
    end else begin
      mag_q_s = {1'b0, div_q_s};
    end
    if (neg_r) begin
      res_s = {(FRAC+2){1'b0}} - mag_q_s;
    end else begin
      res_s = mag_q_s;
    end
  end

  // Control FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      y_r         <= {COMP_W{1'b0}};
      z_r         <= {COMP_W{1'b0}};
      mag_r       <= {MAG_W{1'b0}};
      neg_r       <= 1'b0;
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      zero_vec_r  <= 1'b0;
      nx_r        <= {(FRAC+2){1'b0}};
      ny_r        <= {(FRAC+2){1'b0}};
      nz_r        <= {(FRAC+2){1'b0}};
    end else begin
      if (div_start_s) begin
        neg_r <= start_c_s[COMP_W-1];
        sat_r <= start_sat_s;
      end
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            y_r        <= y;
            z_r        <= z;
            mag_r      <= mag;
            in_ready_r <= 1'b0;
            state_r    <= DIV_X;
          end
        end
        DIV_X: begin
          if (div_done_s) begin
            nx_r    <= res_s;
            state_r <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done_s) begin
            ny_r    <= res_s;
            state_r <= DIV_Z;
          end
        end
        DIV_Z: begin
          if (div_done_s) begin
            nz_r        <= res_s;
            zero_vec_r  <= (mag_r == {MAG_W{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign nx        = nx_r;
  assign ny        = ny_r;
  assign nz        = nz_r;
  assign zero_vec  = zero_vec_r;
endmodule

// File: tb/tb_vec_normalize.sv
// Directed bench for vec_normalize: arithmetic reference model feeding a scoreboard queue,
// checked with immediate assertions when each result appears.
module tb_vec_normalize;
  import vec_pkg::*;

  localparam int FRAC = 16;
  localparam int LAT  = 3 * (FRAC + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [COMP_W-1:0] x, y, z;
  logic [MAG_W-1:0]  mag;
  logic              out_valid;
  logic              out_ready;
  logic [FRAC+1:0]   nx, ny, nz;
  logic              zero_vec;

  typedef struct {
    logic [FRAC+1:0] nx;
    logic [FRAC+1:0] ny;
    logic [FRAC+1:0] nz;
    logic            zv;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  vec_normalize #(.FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .mag       (mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nx        (nx),
    .ny        (ny),
    .nz        (nz),
    .zero_vec  (zero_vec)
  );

  always #5 clk = ~clk;

  function automatic fix_t model(input int c, input int m);
    longint a, q;
    if (m == 0) return fix_t'(0);
    a = (c < 0) ? -longint'(c) : longint'(c);
    if (a > m) q = longint'(1) << FRAC;
    else       q = (a << FRAC) / m;
    if (c < 0) q = -q;
    return fix_t'(q);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one vector at a negedge, record its expected result, return at the negedge after acceptance.
  task automatic send(input int xv, input int yv, input int zv, input int mv);
    exp_t e;
    int   k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    x        = COMP_W'(xv);
    y        = COMP_W'(yv);
    z        = COMP_W'(zv);
    mag      = MAG_W'(mv);
    in_valid = 1'b1;
    e.nx = model(xv, mv);
    e.ny = model(yv, mv);
    e.nz = model(zv, mv);
    e.zv = (mv == 0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x   = COMP_W'($urandom);
    y   = COMP_W'($urandom);
    z   = COMP_W'($urandom);
    mag = MAG_W'($urandom);
    chk("in_ready_low", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk("latency", k, LAT);
  endtask

  // Compare against the scoreboard, optionally stall the consumer, then complete the handshake.
  task automatic recv(input int hold);
    exp_t e;
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("nx", nx, e.nx);
    chk("ny", ny, e.ny);
    chk("nz", nz, e.nz);
    chk("zero_vec", {31'b0, zero_vec}, {31'b0, e.zv});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x   = COMP_W'($urandom);
      mag = MAG_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_nx", nx, e.nx);
      chk("bp_nz", nz, e.nz);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
    chk("in_ready_back", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mv, a, b, c;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; z = '0; mag = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_nx", nx, 18'd0);
    chk("rst_zero_vec", {31'b0, zero_vec}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    send(3, 4, 0, 5);
    wait_out();
    chk("basic_nx_lit", nx, 18'd39321);
    chk("basic_ny_lit", ny, 18'd52428);
    recv(0);

    send(-3, 4, 0, 5);
    wait_out();
    chk("neg_nx_lit", nx, 18'h36667);
    recv(0);

    send(0, 0, 0, 0);
    wait_out();
    chk("zero_vec_lit", {31'b0, zero_vec}, 32'd1);
    recv(0);

    send(3000, 0, -3000, 100);
    wait_out();
    chk("sat_nx_lit", nx, 18'd65536);
    chk("sat_nz_lit", nz, 18'd196608);
    recv(10);

    send(5, -9, 1, 0);
    wait_out();
    recv(0);

    send(-524288, 2047, 524287, 2047);
    wait_out();
    recv(0);

    for (int i = 0; i < 4; i++) begin
      mv = int'($urandom_range(1, 2047));
      a  = int'($urandom_range(0, 2 * mv)) - mv;
      b  = int'($urandom_range(0, 2 * mv)) - mv;
      c  = int'($urandom_range(0, 2 * mv)) - mv;
      send(a, b, c, mv);
      wait_out();
      recv(0);
    end

    send(1000, -1500, 2000, 2047);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_nx", nx, 18'd0);
    chk("midrst_ny", ny, 18'd0);
    chk("midrst_nz", nz, 18'd0);
    chk("midrst_zero_vec", {31'b0, zero_vec}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 0, 7, 7);
    wait_out();
    chk("post_rst_nz_lit", nz, 18'd65536);
    recv(0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
